boreal_debug_regfile: RTL and testbench

Parametrised read-only debug register file: next-generation observation port for JTAG/MCU/logic-analyzer access to Neuro-Core state. Captures N_CH signed observation channels atomically into a shadow bank on a snapshot request, and keeps live and sticky status flags. Serves reads through a valid/ready request/response handshake with auto-increment bursts. Sits beside the core datapath; never drives it.

---
 rtl/boreal_dbg_pkg.sv | 32 +++
 rtl/boreal_peak_hold.sv | 42 ++++
 rtl/boreal_debug_regfile.sv | 170 +++++++++++++++++
 tb/tb_boreal_debug_regfile.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boreal_dbg_pkg.sv
// Shared types and register-map offsets for the Boreal debug register file.
// The offsets are functions of the channel count so that each instance derives its own map.
package boreal_dbg_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } dbgState_t;

    localparam logic [15:0] DEAD_PATTERN = 16'hDEAD;

    function automatic int OFS_FLAGS(input int nCh);
        return nCh;
    endfunction

    function automatic int OFS_STICKY(input int nCh);
        return nCh + 1;
    endfunction

    function automatic int OFS_SEQ(input int nCh);
        return nCh + 2;
    endfunction

    function automatic int OFS_ID(input int nCh);
        return nCh + 3;
    endfunction

    function automatic int OFS_PEAK(input int nCh);
        return nCh + 4;
    endfunction

endpackage

// File: rtl/boreal_peak_hold.sv
// Peak-hold of one signed channel's magnitude, with the most negative input saturated
// to the largest positive value.
module boreal_peak_hold
    import boreal_dbg_pkg::*;
#(
    parameter int DATA_W = 16
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_obs,
    input  logic              i_clr,
    output logic [DATA_W-1:0] o_peak
);

    localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W-1:0] w_abs;
    logic [DATA_W-1:0] r_peak;

    always_comb begin
        w_abs = i_obs;
        if (i_obs == MIN_NEG) begin
            w_abs = MAX_POS;
        end else if (i_obs[DATA_W-1]) begin
            w_abs = -i_obs;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_peak <= '0;
        end else if (i_clr) begin
            r_peak <= w_abs;
        end else if (w_abs > r_peak) begin
            r_peak <= w_abs;
        end
    end

    assign o_peak = r_peak;

endmodule

// File: rtl/boreal_debug_regfile.sv
// Read-only debug register file: snapshot shadow bank, live/sticky flags, and burst reads
// over a valid/ready handshake. Per-channel peak registers exist only with BOREAL_DBG_PEAK_EN.
module boreal_debug_regfile
    import boreal_dbg_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                N_CH     = 6,
    parameter int                N_FLAGS  = 8,
    parameter int                ADDR_W   = 4,
    parameter logic [DATA_W-1:0] ID_VALUE = 16'hB040
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH*DATA_W-1:0] obs_data,
    input  logic [N_FLAGS-1:0]     flags_in,
    input  logic                   snap_req,
    input  logic                   clr_valid,
    input  logic [N_FLAGS-1:0]     clr_mask,
    input  logic                   clr_peak,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [ADDR_W-1:0]      req_len,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   rsp_last,
    output logic                   snap_busy
);

    dbgState_t         r_state, w_stateNext;
    logic [DATA_W-1:0] r_shadow     [N_CH];
    logic [DATA_W-1:0] w_shadowView [N_CH];
    logic [DATA_W-1:0] r_seq, w_seqView;
    logic [N_FLAGS-1:0] r_sticky;
    logic              r_snapPend;
    logic [ADDR_W-1:0] r_addr, r_cnt, r_len, w_rdAddr;
    logic [DATA_W-1:0] w_rdData, w_flagsExt, w_stickyExt;
    logic              w_capture, w_accept, w_beatDone;
    int                w_rdIdx;

`ifdef BOREAL_DBG_PEAK_EN
    logic [DATA_W-1:0] w_peak [N_CH];
    logic              w_clrPeak;

    assign w_clrPeak = clr_valid && clr_peak;

    for (genvar k = 0; k < N_CH; k++) begin : g_peak
        boreal_peak_hold #(.DATA_W(DATA_W)) u_peak (
            .clk    (clk),
            .rst    (rst),
            .i_obs  (obs_data[k*DATA_W +: DATA_W]),
            .i_clr  (w_clrPeak),
            .o_peak (w_peak[k])
        );
    end
`else
    logic w_unusedClrPeak;
    assign w_unusedClrPeak = clr_peak;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        req_ready   = 1'b0;
        w_accept    = 1'b0;
        w_beatDone  = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_stateNext = BURST;
                end
            end
            BURST: begin
                if (rsp_valid && rsp_ready) begin
                    w_beatDone = 1'b1;
                    if (rsp_last) begin
                        w_stateNext = IDLE;
                    end
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // A capture in the accepting cycle must be visible to that burst's first beat.
    assign w_capture = (r_state == IDLE) && (snap_req || r_snapPend);
    assign w_seqView = w_capture ? r_seq + DATA_W'(1) : r_seq;
    assign w_rdAddr  = (r_state == IDLE) ? req_addr : r_addr + ADDR_W'(1);
    assign w_rdIdx   = int'(w_rdAddr);

    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            w_shadowView[k] = w_capture ? obs_data[k*DATA_W +: DATA_W] : r_shadow[k];
        end
        w_flagsExt                 = '0;
        w_flagsExt[N_FLAGS-1:0]    = flags_in;
        w_stickyExt                = '0;
        w_stickyExt[N_FLAGS-1:0]   = r_sticky;
    end

    always_comb begin
        w_rdData = DATA_W'(DEAD_PATTERN);
        for (int k = 0; k < N_CH; k++) begin
            if (w_rdIdx == k) w_rdData = w_shadowView[k];
        end
        if (w_rdIdx == OFS_FLAGS(N_CH))  w_rdData = w_flagsExt;
        if (w_rdIdx == OFS_STICKY(N_CH)) w_rdData = w_stickyExt;
        if (w_rdIdx == OFS_SEQ(N_CH))    w_rdData = w_seqView;
        if (w_rdIdx == OFS_ID(N_CH))     w_rdData = ID_VALUE;
`ifdef BOREAL_DBG_PEAK_EN
        for (int k = 0; k < N_CH; k++) begin
            if (w_rdIdx == OFS_PEAK(N_CH) + k) w_rdData = w_peak[k];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_CH; k++) r_shadow[k] <= '0;
            r_seq      <= '0;
            r_sticky   <= '0;
            r_snapPend <= 1'b0;
            r_addr     <= '0;
            r_cnt      <= '0;
            r_len      <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_last   <= 1'b0;
        end else begin
            r_sticky <= (r_sticky & ~(clr_valid ? clr_mask : '0)) | flags_in;
            if (w_capture) begin
                for (int k = 0; k < N_CH; k++) r_shadow[k] <= w_shadowView[k];
                r_seq      <= w_seqView;
                r_snapPend <= 1'b0;
            end else if (r_state == BURST && snap_req) begin
                r_snapPend <= 1'b1;
            end
            if (w_accept) begin
                r_addr    <= req_addr;
                r_len     <= req_len;
                r_cnt     <= '0;
                rsp_valid <= 1'b1;
                rsp_data  <= w_rdData;
                rsp_last  <= (req_len == '0);
            end else if (w_beatDone) begin
                if (rsp_last) begin
                    rsp_valid <= 1'b0;
                end else begin
                    r_addr   <= w_rdAddr;
                    r_cnt    <= r_cnt + ADDR_W'(1);
                    rsp_data <= w_rdData;
                    rsp_last <= (r_cnt + ADDR_W'(1) == r_len);
                end
            end
        end
    end

    assign snap_busy = r_snapPend;

endmodule

// File: tb/tb_boreal_debug_regfile.sv
// Scoreboard bench for boreal_debug_regfile: a per-cycle register-map model pushes each
// expected beat when it is loaded, and a monitor pops and compares it when consumed.
module tb_boreal_debug_regfile;

    localparam int DATA_W  = 16;
    localparam int N_CH    = 6;
    localparam int N_FLAGS = 8;
    localparam int ADDR_W  = 4;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } beat_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_CH*DATA_W-1:0] obs_data;
    logic [N_FLAGS-1:0]     flags_in, clr_mask;
    logic                   snap_req, clr_valid, clr_peak;
    logic                   req_valid, req_ready, rsp_valid, rsp_ready, rsp_last, snap_busy;
    logic [ADDR_W-1:0]      req_addr, req_len;
    logic [DATA_W-1:0]      rsp_data;

    int          checkCount = 0;
    int          errorCount = 0;
    bit          started = 0;
    bit          randSide = 0;
    logic [15:0] mShadow [N_CH];
    logic [15:0] mPeak [N_CH];
    logic [15:0] mSeq;
    logic [7:0]  mSticky;
    bit          mBusy = 0;
    bit          mPend = 0;
    int          mAddr, mCnt, mLen;
    beat_t       expQ[$];
    logic [15:0] gotLog[$];
    logic [15:0] val;

    always #5 clk = ~clk;

    boreal_debug_regfile dut (
        .clk       (clk),
        .rst       (rst),
        .obs_data  (obs_data),
        .flags_in  (flags_in),
        .snap_req  (snap_req),
        .clr_valid (clr_valid),
        .clr_mask  (clr_mask),
        .clr_peak  (clr_peak),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .snap_busy (snap_busy)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] absSat(input logic [15:0] v);
        int s;
        s = $signed(v);
        if (s < 0) s = -s;
        if (s > 32767) s = 32767;
        return 16'(s);
    endfunction

    function automatic logic [15:0] expRead(input int a, input logic [7:0] liveFlags);
        if (a < N_CH) return mShadow[a];
        if (a == N_CH)     return {8'h00, liveFlags};
        if (a == N_CH + 1) return {8'h00, mSticky};
        if (a == N_CH + 2) return mSeq;
        if (a == N_CH + 3) return 16'hB040;
`ifdef BOREAL_DBG_PEAK_EN
        if (a >= N_CH + 4 && a < 2 * N_CH + 4) return mPeak[a - N_CH - 4];
`endif
        return 16'hDEAD;
    endfunction

    // Reference model: advances once per clock from the sampled inputs.
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_CH; k++) begin
                mShadow[k] = 16'h0;
                mPeak[k]   = 16'h0;
            end
            mSeq    = 16'h0;
            mSticky = 8'h0;
            mBusy   = 0;
            mPend   = 0;
            expQ.delete();
            started = 1;
        end else if (started) begin
            if (!mBusy && (snap_req || mPend)) begin
                for (int k = 0; k < N_CH; k++) mShadow[k] = obs_data[k*16 +: 16];
                mSeq  = mSeq + 16'd1;
                mPend = 0;
            end else if (mBusy && snap_req) begin
                mPend = 1;
            end
            if (!mBusy && req_valid) begin
                mBusy = 1;
                mAddr = int'(req_addr);
                mLen  = int'(req_len);
                mCnt  = 0;
                expQ.push_back('{data: expRead(mAddr, flags_in), last: (mLen == 0)});
            end else if (mBusy && rsp_ready) begin
                if (mCnt == mLen) begin
                    mBusy = 0;
                end else begin
                    mCnt++;
                    mAddr = (mAddr + 1) % 16;
                    expQ.push_back('{data: expRead(mAddr, flags_in), last: (mCnt == mLen)});
                end
            end
            mSticky = (mSticky & ~(clr_valid ? clr_mask : 8'h00)) | flags_in;
            for (int k = 0; k < N_CH; k++) begin
                if (clr_valid && clr_peak) mPeak[k] = absSat(obs_data[k*16 +: 16]);
                else if (absSat(obs_data[k*16 +: 16]) > mPeak[k]) mPeak[k] = absSat(obs_data[k*16 +: 16]);
            end
        end
    end

    // Monitor: samples just after the falling edge, pops one expectation per handshake.
    always @(negedge clk) begin
        #1;
        if (started) begin
            checkOutput("reqReady", 32'(req_ready), 32'(!mBusy));
            checkOutput("rspValid", 32'(rsp_valid), 32'(mBusy));
            checkOutput("snapBusy", 32'(snap_busy), 32'(mPend));
            if (rsp_valid) begin
                if (expQ.size() == 0) begin
                    checkCount++;
                    errorCount++;
                    $display("[TB] FAIL rspUnexpected: got beat %h expected none at %0t", rsp_data, $time);
                end else begin
                    checkOutput("rspData", 32'(rsp_data), 32'(expQ[0].data));
                    checkOutput("rspLast", 32'(rsp_last), 32'(expQ[0].last));
                    if (rsp_ready) begin
                        gotLog.push_back(rsp_data);
                        void'(expQ.pop_front());
                    end
                end
            end
        end
    end

    task automatic sideRandom();
        for (int k = 0; k < N_CH; k++) begin
            obs_data[k*16 +: 16] = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
        end
        flags_in  = 8'($urandom);
        snap_req  = ($urandom_range(0, 3) == 0);
        clr_valid = ($urandom_range(0, 3) == 0);
        clr_mask  = 8'($urandom);
        clr_peak  = 1'($urandom_range(0, 1));
    endtask

    // Issues one burst from a falling edge; stallAt -1 = always ready, -2 = random ready.
    task automatic applyStimulus(input int addr, input int len, input int stallAt, input int stallCycles);
        int cyc = 0;
        int beat = 0;
        int stallLeft = stallCycles;
        req_valid = 1'b1;
        req_addr  = ADDR_W'(addr);
        req_len   = ADDR_W'(len);
        rsp_ready = 1'b1;
        if (randSide) sideRandom();
        @(negedge clk);
        req_valid = 1'b0;
        while (mBusy && cyc < 200) begin
            if (stallAt == -2) begin
                rsp_ready = ($urandom_range(0, 2) != 0);
            end else if (beat == stallAt && stallLeft > 0) begin
                rsp_ready = 1'b0;
                stallLeft--;
            end else begin
                rsp_ready = 1'b1;
            end
            if (rsp_ready) beat++;
            if (randSide) sideRandom();
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 200) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL burstTimeout: got %0d cycles required under 200", cyc);
        end
        snap_req  = 1'b0;
        clr_valid = 1'b0;
    endtask

    task automatic readReg(input int addr, output logic [15:0] data);
        applyStimulus(addr, 0, -1, 0);
        data = (gotLog.size() > 0) ? gotLog[gotLog.size()-1] : 16'hxxxx;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no finish required finish before 1ms");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; obs_data = '0; flags_in = '0; snap_req = 0; clr_valid = 0;
        clr_mask = '0; clr_peak = 0; req_valid = 0; req_addr = '0; req_len = '0; rsp_ready = 0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("resetReqReady", 32'(req_ready), 32'd1);
        checkOutput("resetRspValid", 32'(rsp_valid), 32'd0);
        checkOutput("resetRspData", 32'(rsp_data), 32'd0);
        checkOutput("resetRspLast", 32'(rsp_last), 32'd0);
        checkOutput("resetSnapBusy", 32'(snap_busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        readReg(9, val);  checkOutput("idReg", 32'(val), 32'hB040);
        readReg(8, val);  checkOutput("seqAfterReset", 32'(val), 32'd0);

        for (int k = 0; k < N_CH; k++) obs_data[k*16 +: 16] = 16'(k * 16'h0111);
        obs_data[0 +: 16]  = 16'h1234;
        obs_data[80 +: 16] = 16'h8001;
        snap_req = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
        applyStimulus(0, 5, -1, 0);
        checkOutput("shadowCh0", 32'(gotLog[gotLog.size()-6]), 32'h1234);
        checkOutput("shadowCh5", 32'(gotLog[gotLog.size()-1]), 32'h8001);
        readReg(8, val);  checkOutput("seqAfterSnap", 32'(val), 32'd1);

        applyStimulus(0, 5, 2, 3);
        checkOutput("stallCh2", 32'(gotLog[gotLog.size()-4]), 32'h0222);

        fork
            applyStimulus(0, 5, 3, 2);
            begin
                @(negedge clk);
                obs_data[0 +: 16] = 16'hAAAA; snap_req = 1'b1;
                @(negedge clk);
                snap_req = 1'b0;
                #1 checkOutput("snapPending", 32'(snap_busy), 32'd1);
                @(negedge clk);
                obs_data[0 +: 16] = 16'h5A5A; snap_req = 1'b1;
                @(negedge clk);
                snap_req = 1'b0;
            end
        join
        checkOutput("burstStableCh0", 32'(gotLog[gotLog.size()-6]), 32'h1234);
        checkOutput("burstStableCh5", 32'(gotLog[gotLog.size()-1]), 32'h8001);
        readReg(0, val);  checkOutput("deferredCapture", 32'(val), 32'h5A5A);
        readReg(8, val);  checkOutput("seqCoalesced", 32'(val), 32'd2);

        flags_in = 8'h04; @(negedge clk); flags_in = 8'h00; @(negedge clk);
        readReg(7, val);  checkOutput("stickySet", 32'(val), 32'h0004);
        flags_in = 8'h04; clr_valid = 1'b1; clr_mask = 8'h04;
        @(negedge clk);
        clr_valid = 1'b0;
        readReg(7, val);  checkOutput("stickySetWins", 32'(val), 32'h0004);
        flags_in = 8'h00; @(negedge clk);
        clr_valid = 1'b1; @(negedge clk); clr_valid = 1'b0;
        readReg(7, val);  checkOutput("stickyCleared", 32'(val), 32'h0000);

        obs_data[16 +: 16] = 16'd100;  @(negedge clk);
        obs_data[16 +: 16] = 16'h8000; @(negedge clk);
        obs_data[16 +: 16] = 16'd5;    @(negedge clk);
        readReg(11, val);
`ifdef BOREAL_DBG_PEAK_EN
        checkOutput("peakSaturate", 32'(val), 32'h7FFF);
`else
        checkOutput("peakAbsent", 32'(val), 32'hDEAD);
`endif
        clr_valid = 1'b1; clr_peak = 1'b1; clr_mask = 8'h00;
        @(negedge clk);
        clr_valid = 1'b0; clr_peak = 1'b0;
        readReg(11, val);
`ifdef BOREAL_DBG_PEAK_EN
        checkOutput("peakCleared", 32'(val), 32'd5);
`else
        checkOutput("peakClrIgnored", 32'(val), 32'hDEAD);
`endif
        readReg(15, val);

        req_valid = 1'b1; req_addr = '0; req_len = 4'd7; rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0; snap_req = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("abortRspValid", 32'(rsp_valid), 32'd0);
        checkOutput("abortReqReady", 32'(req_ready), 32'd1);
        checkOutput("abortSnapDropped", 32'(snap_busy), 32'd0);
        @(negedge clk);
        readReg(8, val);  checkOutput("abortSeq", 32'(val), 32'd0);

        randSide = 1;
        for (int t = 0; t < 40; t++) begin
            int idle = $urandom_range(0, 3);
            for (int i = 0; i < idle; i++) begin
                sideRandom();
                @(negedge clk);
            end
            applyStimulus($urandom_range(0, 15), $urandom_range(0, 15), -2, 0);
        end
        randSide = 0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
